exc_ctrl: RTL and testbench

- Exception/interrupt sequencer for the 32-bit pipelined core.
- Collects the synchronous event sources (overflow, trap) and the external interrupt lines, and selects one by fixed priority.
- Drives the `exception` strobe into the interrupt-address register, flushes the pipeline, redirects fetch to the handler vector, and sequences the return on `eret`.

---
 rtl/exc_pkg.sv | 8 +
 rtl/exc_ctrl_if.sv | 16 +
 rtl/exc_prio_enc.sv | 28 ++
 rtl/exc_ctrl.sv | 94 +++++++++
 tb/tb_exc_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/exc_pkg.sv
// exc_pkg: shared state encoding and cause codes for the exception sequencer
package exc_pkg;
  typedef enum logic [2:0] {IDLE, TAKE, FLUSH, HANDLER, RETURN} exc_state_e;
  localparam logic [7:0] CAUSE_OVF = 8'h01;
  localparam logic [7:0] CAUSE_TRAP = 8'h02;
  localparam logic [7:0] CAUSE_IRQ_BASE = 8'h10;
  localparam int DF_BIT = 7;
endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: pipeline-side event inputs and control outputs of the exception sequencer
interface exc_ctrl_if #(parameter int NUM_IRQ = 4);
  logic [NUM_IRQ-1:0] irq, mask_din, irq_ack;
  logic trap, overflow, eret, stall, mask_wr;
  logic exception, flush, pc_sel_vec, pc_sel_iar, in_handler;
  logic [31:0] vector;
  logic [7:0] cause;
  modport master (
    output irq, trap, overflow, eret, stall, mask_wr, mask_din,
    input exception, flush, pc_sel_vec, pc_sel_iar, vector, cause, in_handler, irq_ack
  );
  modport slave (
    input irq, trap, overflow, eret, stall, mask_wr, mask_din,
    output exception, flush, pc_sel_vec, pc_sel_iar, vector, cause, in_handler, irq_ack
  );
endinterface

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: fixed-priority pick of {overflow, trap, irq[0..N-1]}, lowest irq index wins
module exc_prio_enc import exc_pkg::*; #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ+1:0] pend,
  output logic               valid,
  output logic [7:0]         cause,
  output logic [NUM_IRQ-1:0] ack
);
  always_comb begin
    valid = |pend;
    cause = 8'h00;
    ack = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pend[i]) begin
        cause = CAUSE_IRQ_BASE + 8'(i);
        ack = NUM_IRQ'(1) << i;
      end
    if (pend[NUM_IRQ]) begin
      cause = CAUSE_TRAP;
      ack = '0;
    end
    if (pend[NUM_IRQ+1]) begin
      cause = CAUSE_OVF;
      ack = '0;
    end
  end
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt sequencer (take, flush, vector, handler, return)
// Optional EXC_IRQ_LATCH_EN: per-line rising-edge irq pending flops cleared by irq_ack.
module exc_ctrl import exc_pkg::*; #(
  parameter int          NUM_IRQ      = 4,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] VEC_ADDR     = 32'h0000_8000
) (
  input logic       clk,
  input logic       reset,
  exc_ctrl_if.slave bus
);
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);
  exc_state_e state;
  logic [2:0] cnt;
  logic [NUM_IRQ-1:0] mask, irq_src, enc_ack;
  logic [7:0] enc_cause;
  logic enc_valid;
`ifdef EXC_IRQ_LATCH_EN
  logic [NUM_IRQ-1:0] irq_d, irq_pend;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      irq_d <= '0;
      irq_pend <= '0;
    end else begin
      irq_d <= bus.irq;
      irq_pend <= (irq_pend & ~bus.irq_ack) | (bus.irq & ~irq_d);
    end
  assign irq_src = irq_pend;
`else
  assign irq_src = bus.irq;
`endif
  exc_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
    .pend ({bus.overflow, bus.trap, irq_src & mask}),
    .valid(enc_valid),
    .cause(enc_cause),
    .ack  (enc_ack)
  );
  assign bus.vector = VEC_ADDR;
  // outputs are set on the transition into the state that owns them
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      mask <= '1;
      cnt <= '0;
      bus.cause <= '0;
      bus.irq_ack <= '0;
      bus.exception <= 1'b0;
      bus.flush <= 1'b0;
      bus.pc_sel_vec <= 1'b0;
      bus.pc_sel_iar <= 1'b0;
      bus.in_handler <= 1'b0;
    end else begin
      if (bus.mask_wr) mask <= bus.mask_din;
      bus.exception <= 1'b0;
      bus.irq_ack <= '0;
      bus.pc_sel_vec <= 1'b0;
      bus.pc_sel_iar <= 1'b0;
      case (state)
        IDLE: if (enc_valid && !bus.stall) begin
          state <= TAKE;
          bus.cause <= enc_cause;
          bus.irq_ack <= enc_ack;
          bus.exception <= 1'b1;
          bus.flush <= 1'b1;
        end
        TAKE: begin
          state <= FLUSH;
          cnt <= CNT_INIT;
          bus.pc_sel_vec <= (CNT_INIT == 3'd0);
        end
        FLUSH: if (cnt == 3'd0) begin
          state <= HANDLER;
          bus.flush <= 1'b0;
          bus.in_handler <= 1'b1;
        end else begin
          cnt <= cnt - 3'd1;
          bus.pc_sel_vec <= (cnt == 3'd1);
        end
        HANDLER: begin
          if (bus.trap || bus.overflow) bus.cause[DF_BIT] <= 1'b1;
          if (bus.eret) begin
            state <= RETURN;
            bus.in_handler <= 1'b0;
            bus.pc_sel_iar <= 1'b1;
            bus.flush <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          bus.flush <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: vector table, directed corner sequences and a random run against a schedule model
module tb_exc_ctrl;
  localparam int N = 4;
  localparam int FC = 2;
  localparam logic [31:0] VEC = 32'h0000_8000;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  exc_ctrl_if #(.NUM_IRQ(N)) bus ();
  exc_ctrl #(.NUM_IRQ(N), .FLUSH_CYCLES(FC), .VEC_ADDR(VEC)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [N-1:0] irq;
    logic         trap;
    logic         ovf;
    logic [7:0]   cause;
    logic [N-1:0] ack;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic outs(input string tag, input logic e, input logic f, input logic v, input logic r,
                      input logic h, input logic [7:0] c, input logic [N-1:0] a);
    chk({tag, "/exception"}, 32'(bus.exception), 32'(e));
    chk({tag, "/flush"}, 32'(bus.flush), 32'(f));
    chk({tag, "/pc_sel_vec"}, 32'(bus.pc_sel_vec), 32'(v));
    chk({tag, "/pc_sel_iar"}, 32'(bus.pc_sel_iar), 32'(r));
    chk({tag, "/in_handler"}, 32'(bus.in_handler), 32'(h));
    chk({tag, "/cause"}, 32'(bus.cause), 32'(c));
    chk({tag, "/irq_ack"}, 32'(bus.irq_ack), 32'(a));
  endtask
  task automatic quiet();
    bus.irq = '0;
    bus.trap = 1'b0;
    bus.overflow = 1'b0;
    bus.eret = 1'b0;
    bus.stall = 1'b0;
    bus.mask_wr = 1'b0;
    bus.mask_din = '0;
  endtask
  task automatic do_reset();
    quiet();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    int tk, rt;
    logic idle, inh;
    logic [7:0] mc;
    logic [N-1:0] mm, ma, pend;
    tbl[0] = '{4'b0100, 1'b0, 1'b0, 8'h12, 4'b0100};
    tbl[1] = '{4'b1111, 1'b1, 1'b1, 8'h01, 4'b0000};
    tbl[2] = '{4'b1111, 1'b1, 1'b0, 8'h02, 4'b0000};
    tbl[3] = '{4'b1010, 1'b0, 1'b0, 8'h11, 4'b0010};
    tbl[4] = '{4'b1000, 1'b0, 1'b0, 8'h13, 4'b1000};
    tbl[5] = '{4'b0001, 1'b0, 1'b1, 8'h01, 4'b0000};
    tbl[6] = '{4'b0000, 1'b1, 1'b0, 8'h02, 4'b0000};
    do_reset();
    outs("reset", 0, 0, 0, 0, 0, 8'h00, '0);
    chk("reset/vector", bus.vector, VEC);
    for (int k = 0; k < 7; k++) begin
      do_reset();
      bus.irq = tbl[k].irq;
      bus.trap = tbl[k].trap;
      bus.overflow = tbl[k].ovf;
      @(negedge clk);
      quiet();
      outs($sformatf("tbl%0d", k), 1, 1, 0, 0, 0, tbl[k].cause, tbl[k].ack);
    end
    // single irq through to handler, then double fault and return
    do_reset();
    bus.irq = 4'b0100;
    @(negedge clk);
    bus.irq = '0;
    outs("irq/take", 1, 1, 0, 0, 0, 8'h12, 4'b0100);
    @(negedge clk);
    outs("irq/flush1", 0, 1, 0, 0, 0, 8'h12, '0);
    @(negedge clk);
    outs("irq/flush2", 0, 1, 1, 0, 0, 8'h12, '0);
    @(negedge clk);
    outs("irq/handler", 0, 0, 0, 0, 1, 8'h12, '0);
    bus.irq = 4'b0001;
    bus.trap = 1'b1;
    @(negedge clk);
    quiet();
    outs("dfault", 0, 0, 0, 0, 1, 8'h92, '0);
    bus.eret = 1'b1;
    @(negedge clk);
    bus.eret = 1'b0;
    outs("eret/return", 0, 1, 0, 1, 0, 8'h92, '0);
    @(negedge clk);
    outs("eret/idle", 0, 0, 0, 0, 0, 8'h92, '0);
    // stall holds off a take; masked line never taken after stall drops
    do_reset();
    bus.irq = 4'b0001;
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.mask_wr = (k == 1);
      @(negedge clk);
      chk("stall/exception", 32'(bus.exception), 32'd0);
    end
    bus.mask_wr = 1'b0;
    bus.stall = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("masked/exception", 32'(bus.exception), 32'd0);
    end
    // a same-cycle mask write does not affect that cycle's evaluation
    do_reset();
    bus.irq = 4'b0001;
    bus.mask_wr = 1'b1;
    @(negedge clk);
    quiet();
    outs("maskwr_same", 1, 1, 0, 0, 0, 8'h10, 4'b0001);
    // reset during flush aborts at once
    do_reset();
    bus.overflow = 1'b1;
    @(negedge clk);
    quiet();
    @(negedge clk);
    reset = 1'b0;
    #1;
    outs("rst_flush", 0, 0, 0, 0, 0, 8'h00, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      outs("rst_flush/after", 0, 0, 0, 0, 0, 8'h00, '0);
    end
    // random run against a take/return schedule model
    do_reset();
    tk = -100;
    rt = -50;
    mc = 8'h00;
    mm = '1;
    ma = '0;
    for (int n = 0; n < 3000; n++) begin
      idle = (rt > tk) && (n > rt);
      inh = (n > tk + FC) && !((rt > tk) && (n >= rt));
      outs("rnd", n == tk, ((n >= tk) && (n <= tk + FC)) || (n == rt), n == tk + FC, n == rt, inh, mc,
           (n == tk) ? ma : '0);
      bus.irq = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      bus.trap = ($urandom_range(0, 9) == 0);
      bus.overflow = ($urandom_range(0, 9) == 0);
      bus.eret = ($urandom_range(0, 4) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.mask_wr = ($urandom_range(0, 9) == 0);
      bus.mask_din = N'($urandom);
      pend = bus.irq & mm;
      if (idle && !bus.stall && (bus.overflow || bus.trap || pend != '0)) begin
        tk = n + 1;
        ma = '0;
        if (bus.overflow) mc = 8'h01;
        else if (bus.trap) mc = 8'h02;
        else
          for (int i = N - 1; i >= 0; i--)
            if (pend[i]) begin
              mc = 8'h10 + 8'(i);
              ma = '0;
              ma[i] = 1'b1;
            end
      end
      if (inh) begin
        if (bus.trap || bus.overflow) mc[7] = 1'b1;
        if (bus.eret) rt = n + 1;
      end
      if (bus.mask_wr) mm = bus.mask_din;
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
